fft_job_arbiter: RTL and testbench

FFT_JOB_ARBITER -- requirements
Module: fft_job_arbiter

---
 rtl/fft_arb_pkg.sv | 7 +
 rtl/fft_rr_arb2.sv | 9 +
 rtl/fft_job_arbiter.sv | 113 +++++++++++
 tb/tb_fft_job_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_arb_pkg.sv
// fft_arb_pkg: shared FSM state encoding and default sizes for the FFT job arbiter.
package fft_arb_pkg;
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESULT} state_t;
    localparam int SAMPLE_W_DEF = 16;
    localparam int TIMEOUT_DEF  = 64;
    localparam int JOBCNT_W     = 8;
endpackage

// File: rtl/fft_rr_arb2.sv
// fft_rr_arb2: two-way round-robin grant; on a tie the requester not granted last time wins.
module fft_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);
    assign grant[0] = req[0] && (!req[1] || last_grant);
    assign grant[1] = req[1] && (!req[0] || !last_grant);
endmodule

// File: rtl/fft_job_arbiter.sv
// fft_job_arbiter: round-robin feeds jobs from two requesters to one FFT engine and returns results.
// Define FFT_ARB_TIMEOUT_EN to add a WAIT-state watchdog that returns an error result.
module fft_job_arbiter
    import fft_arb_pkg::*;
#(
    parameter int SAMPLE_W       = SAMPLE_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [4*SAMPLE_W-1:0] req0_samples,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [4*SAMPLE_W-1:0] req1_samples,
    output logic                  eng_start,
    output logic [4*SAMPLE_W-1:0] eng_samples,
    input  logic                  eng_done,
    input  logic [4*SAMPLE_W-1:0] eng_freq,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_id,
    output logic [4*SAMPLE_W-1:0] res_data,
    output logic                  res_err,
    output logic                  busy,
    output logic [JOBCNT_W-1:0]   job_count
);
    state_t     state;
    logic       last_grant;
    logic [1:0] grant;

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_chk
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    fft_rr_arb2 u_arb (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign req0_ready = state == S_IDLE && grant[0];
    assign req1_ready = state == S_IDLE && grant[1];
    assign busy       = state != S_IDLE;

`ifdef FFT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt;
    logic             err_q;
    logic             timeout;
    assign timeout = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    assign res_err = err_q;
`else
    assign res_err = 1'b0;
`endif

    // In IDLE a non-zero grant is already the handshake, since ready mirrors grant there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            last_grant  <= 1'b1;
            job_count   <= '0;
            eng_start   <= 1'b0;
            eng_samples <= '0;
            res_valid   <= 1'b0;
            res_id      <= 1'b0;
            res_data    <= '0;
`ifdef FFT_ARB_TIMEOUT_EN
            cnt         <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (|grant) begin
                    eng_samples <= grant[1] ? req1_samples : req0_samples;
                    res_id      <= grant[1];
                    last_grant  <= grant[1];
                    eng_start   <= 1'b1;
                    state       <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    eng_start <= 1'b0;
                    state     <= S_WAIT;
`ifdef FFT_ARB_TIMEOUT_EN
                    cnt       <= '0;
`endif
                end
                S_WAIT: if (eng_done) begin
                    res_data  <= eng_freq;
                    res_valid <= 1'b1;
                    state     <= S_RESULT;
`ifdef FFT_ARB_TIMEOUT_EN
                    err_q     <= 1'b0;
                end else if (timeout) begin
                    res_data  <= '0;
                    err_q     <= 1'b1;
                    res_valid <= 1'b1;
                    state     <= S_RESULT;
                end else begin
                    cnt       <= cnt + 1'b1;
`endif
                end
                S_RESULT: if (res_ready) begin
                    res_valid <= 1'b0;
                    job_count <= job_count + 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_job_arbiter.sv
// tb_fft_job_arbiter: directed stimulus with a result scoreboard and a toy 4-point engine model.
module tb_fft_job_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [63:0] req0_samples, req1_samples;
    logic        eng_start, eng_done;
    logic [63:0] eng_samples, eng_freq;
    logic        res_valid, res_ready, res_id, res_err, busy;
    logic [63:0] res_data;
    logic [7:0]  job_count;

    typedef struct packed {
        logic        id;
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_jobs = 0;
    int   eng_delay = 3;
    bit   eng_mute = 0;

    localparam logic [63:0] A_S = {16'd1, 16'd1, 16'd1, 16'd1}, A_F = {16'd0, 16'd0, 16'd0, 16'd4};
    localparam logic [63:0] B_S = {16'd0, 16'd1, 16'd3, 16'd5}, B_F = {16'd3, 16'd3, 16'd4, 16'd9};
    localparam logic [63:0] C_S = {16'd0, 16'd2, 16'd0, 16'd2}, C_F = {16'd0, 16'd4, 16'd0, 16'd4};
    localparam logic [63:0] D_S = {16'd1, 16'd0, 16'd1, 16'd0}, D_F = {16'd0, 16'hFFFE, 16'd0, 16'd2};
    localparam logic [63:0] E_S = {16'd0, 16'd0, 16'd0, 16'd7}, E_F = {16'd0, 16'd7, 16'd7, 16'd7};
    localparam logic [63:0] F_S = {16'd0, 16'd0, 16'd0, 16'd1}, F_F = {16'd0, 16'd1, 16'd1, 16'd1};

    always #5 clk = ~clk;

    fft_job_arbiter #(.SAMPLE_W(16), .TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_samples (req0_samples),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_samples (req1_samples),
        .eng_start    (eng_start),
        .eng_samples  (eng_samples),
        .eng_done     (eng_done),
        .eng_freq     (eng_freq),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_id       (res_id),
        .res_data     (res_data),
        .res_err      (res_err),
        .busy         (busy),
        .job_count    (job_count)
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Real-valued toy transform: X0=sum, X1=x0-x2, X2=alternating sum, X3=x1-x3.
    function automatic logic [63:0] model(logic [63:0] s);
        logic [15:0] x0, x1, x2, x3;
        {x3, x2, x1, x0} = s;
        return {x1 - x3, x0 - x1 + x2 - x3, x0 - x2, x0 + x1 + x2 + x3};
    endfunction

    logic [63:0] eng_cap;
    always begin
        @(negedge clk);
        if (eng_start && !eng_mute) begin
            eng_cap = eng_samples;
            repeat (eng_delay - 1) @(negedge clk);
            eng_freq = model(eng_cap);
            eng_done = 1'b1;
            @(negedge clk);
            eng_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got id=%0d data=%h expected no result", res_id, res_data);
            end else begin
                e = exp_q.pop_front();
                chk("res_id", 64'(res_id), 64'(e.id));
                chk("res_data", res_data, e.data);
                chk("res_err", 64'(res_err), 64'(e.err));
                exp_jobs++;
            end
        end
    end

    task automatic cycle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_res(logic id, logic [63:0] d, logic e);
        exp_q.push_back({id, d, e});
    endtask

    task automatic send(input logic id, input logic [63:0] s);
        bit ok = 0;
        if (id) begin req1_valid = 1'b1; req1_samples = s; end
        else begin req0_valid = 1'b1; req0_samples = s; end
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            ok = id ? req1_ready : req0_ready;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: req%0d ready got 0 expected 1", id);
            if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        chk("eng_start", 64'(eng_start), 64'd1);
        chk("eng_samples", eng_samples, s);
        cycle(1);
        chk("eng_start_pulse", 64'(eng_start), 64'd0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending got %0d expected 0", exp_q.size());
            exp_q.delete();
        end
        cycle(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req0_valid = 0; req1_valid = 0; req0_samples = '0; req1_samples = '0;
        res_ready = 1'b1; eng_done = 1'b0; eng_freq = '0;
        cycle(2);
        chk("rst_eng_start", 64'(eng_start), 0);
        chk("rst_eng_samples", eng_samples, 0);
        chk("rst_res_valid", 64'(res_valid), 0);
        chk("rst_res_id", 64'(res_id), 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_err", 64'(res_err), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_job_count", 64'(job_count), 0);
        rst = 1'b0;
        cycle(1);

        expect_res(0, A_F, 0);
        send(0, A_S);
        wait_drain();
        chk("single_job_count", 64'(job_count), 64'd1);

        // Both requesters valid while reset releases: requester 0 wins the first tie.
        rst = 1'b1; req0_valid = 1; req0_samples = C_S; req1_valid = 1; req1_samples = B_S;
        cycle(1);
        chk("rst2_job_count", 64'(job_count), 0);
        rst = 1'b0;
        exp_jobs = 0;
        expect_res(0, C_F, 0);
        expect_res(1, B_F, 0);
        fork send(0, C_S); send(1, B_S); join
        wait_drain();
        expect_res(0, A_F, 0);
        expect_res(1, D_F, 0);
        fork send(0, A_S); send(1, D_S); join
        wait_drain();
        expect_res(0, C_F, 0);
        send(0, C_S);
        wait_drain();
        expect_res(1, B_F, 0);
        expect_res(0, E_F, 0);
        fork send(1, B_S); send(0, E_S); join
        wait_drain();
        chk("contention_job_count", 64'(job_count), 64'(exp_jobs % 256));

        res_ready = 1'b0;
        expect_res(0, E_F, 0);
        expect_res(1, F_F, 0);
        send(0, E_S);
        req1_valid = 1'b1;
        req1_samples = F_S;
        for (int n = 0; n < 50 && !res_valid; n++) @(negedge clk);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("bp_res_valid", 64'(res_valid), 64'd1);
            chk("bp_res_data", res_data, E_F);
            chk("bp_res_id", 64'(res_id), 0);
            chk("bp_req1_ready", 64'(req1_ready), 0);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        send(1, F_S);
        wait_drain();
        chk("bp_job_count", 64'(job_count), 64'(exp_jobs % 256));

        eng_delay = 6;
        send(0, C_S);
        cycle(1);
        chk("midwait_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        cycle(1);
        chk("midwait_rst_busy", 64'(busy), 0);
        chk("midwait_rst_samples", eng_samples, 0);
        rst = 1'b0;
        exp_jobs = 0;
        cycle(12);
        chk("midwait_res_valid", 64'(res_valid), 0);
        chk("midwait_busy_after", 64'(busy), 0);
        chk("midwait_job_count", 64'(job_count), 0);

        eng_delay = 2;
        for (int i = 0; i < 256; i++) begin
            logic [15:0] v;
            v = 16'(i);
            expect_res(v[0], {16'd0, v, v, v}, 0);
            send(v[0], {48'd0, v});
        end
        wait_drain();
        chk("wrap_exp_jobs", 64'(exp_jobs), 64'd256);
        chk("wrap_job_count", 64'(job_count), 0);

        eng_freq = 64'hDEAD_BEEF;
        eng_done = 1'b1;
        cycle(1);
        eng_done = 1'b0;
        cycle(3);
        chk("stray_busy", 64'(busy), 0);
        chk("stray_res_valid", 64'(res_valid), 0);
        eng_delay = 3;
        expect_res(1, F_F, 0);
        send(1, F_S);
        wait_drain();
        chk("stray_job_count", 64'(job_count), 64'd1);

`ifdef FFT_ARB_TIMEOUT_EN
        eng_mute = 1;
        expect_res(0, 64'd0, 1);
        send(0, A_S);
        cycle(7);
        chk("timeout_early", 64'(res_valid), 0);
        cycle(1);
        chk("timeout_valid", 64'(res_valid), 64'd1);
        chk("timeout_err", 64'(res_err), 64'd1);
        wait_drain();
        eng_mute = 0;
        eng_delay = 9;
        expect_res(1, D_F, 0);
        send(1, D_S);
        cycle(8);
        chk("done_last_cycle_valid", 64'(res_valid), 64'd1);
        wait_drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
